// File: rtl/key_event_pkg.sv
`default_nettype none
// ============================================================================
// Module      : key_event_pkg
// Description : Shared defaults and width helper for the key event filter.
// Revision    : 1.0 - initial release
// ============================================================================
package key_event_pkg;

    // Default tick length in milliseconds
    localparam int C_TICK_MS            = 1;
    // Default debounce window, in ticks
    localparam int C_DEBOUNCE_TICKS     = 10;
    // Default delay from press to first auto-repeat, in ticks
    localparam int C_REPEAT_DELAY_TICKS = 500;
    // Default interval between later auto-repeats, in ticks
    localparam int C_REPEAT_RATE_TICKS  = 100;

    // Counter width able to hold 0 .. value-1, never narrower than one bit
    function automatic int clog2_min1(input int value);
        int w;
        w = $clog2(value);
        return (w < 1) ? 1 : w;
    endfunction

endpackage : key_event_pkg
`default_nettype wire

// File: rtl/key_debounce_channel.sv
`default_nettype none
// ============================================================================
// Module      : key_debounce_channel
// Description : One key: 2-flop synchronizer, tick-based debounce counter,
//               press/release event flops and optional auto-repeat counter.
//               Auto-repeat is built only when KEY_EVENT_REPEAT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module key_debounce_channel
    import key_event_pkg::*;
#(
    parameter int DEBOUNCE_TICKS     = C_DEBOUNCE_TICKS,
    parameter int REPEAT_DELAY_TICKS = C_REPEAT_DELAY_TICKS,
    parameter int REPEAT_RATE_TICKS  = C_REPEAT_RATE_TICKS
) (
    input  logic clk,
    input  logic rst,
    input  logic i_tick,
    input  logic i_key,
    output logic o_pressed,
    output logic o_press,
    output logic o_release,
    output logic o_repeat
);

    localparam int                C_DB_W    = clog2_min1(DEBOUNCE_TICKS);
    localparam logic [C_DB_W-1:0] C_DB_LAST = C_DB_W'(DEBOUNCE_TICKS - 1);

    logic              r_sync1;
    logic              r_sync2;
    logic [C_DB_W-1:0] r_db_cnt;
    logic              r_pressed;
    logic              r_press;
    logic              r_release;

    logic w_mismatch;
    logic w_flip;
    logic w_rise;
    logic w_fall;

    // The debounced level flips only on a tick that completes the mismatch run
    assign w_mismatch = r_sync2 ^ r_pressed;
    assign w_flip     = w_mismatch & i_tick & (r_db_cnt == C_DB_LAST);
    assign w_rise     = w_flip & r_sync2;
    assign w_fall     = w_flip & ~r_sync2;

    // Two-flop synchronizer for the asynchronous key level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_key;
            r_sync2 <= r_sync1;
        end
    end

    // Debounce counter, debounced level and one-cycle press/release events
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_db_cnt  <= '0;
            r_pressed <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_press   <= w_rise;
            r_release <= w_fall;
            if (!w_mismatch) begin
                r_db_cnt <= '0;
            end else if (i_tick) begin
                if (w_flip) begin
                    r_pressed <= r_sync2;
                    r_db_cnt  <= '0;
                end else begin
                    r_db_cnt <= r_db_cnt + 1'b1;
                end
            end
        end
    end

    assign o_pressed = r_pressed;
    assign o_press   = r_press;
    assign o_release = r_release;

`ifdef KEY_EVENT_REPEAT_EN
    localparam int C_RP_MAX = (REPEAT_DELAY_TICKS > REPEAT_RATE_TICKS) ?
                              REPEAT_DELAY_TICKS : REPEAT_RATE_TICKS;
    localparam int                C_RP_W     = clog2_min1(C_RP_MAX);
    localparam logic [C_RP_W-1:0] C_RP_DELAY = C_RP_W'(REPEAT_DELAY_TICKS - 1);
    localparam logic [C_RP_W-1:0] C_RP_RATE  = C_RP_W'(REPEAT_RATE_TICKS - 1);

    logic [C_RP_W-1:0] r_rep_cnt;
    logic              r_repeat;

    // Auto-repeat countdown; a coinciding release suppresses the repeat pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rep_cnt <= '0;
            r_repeat  <= 1'b0;
        end else begin
            r_repeat <= 1'b0;
            if (w_rise) begin
                r_rep_cnt <= C_RP_DELAY;
            end else if (!r_pressed || w_fall) begin
                r_rep_cnt <= '0;
            end else if (i_tick) begin
                if (r_rep_cnt == '0) begin
                    r_repeat  <= 1'b1;
                    r_rep_cnt <= C_RP_RATE;
                end else begin
                    r_rep_cnt <= r_rep_cnt - 1'b1;
                end
            end
        end
    end

    assign o_repeat = r_repeat;
`else
    assign o_repeat = 1'b0;
`endif

endmodule : key_debounce_channel
`default_nettype wire

// File: rtl/key_event_filter.sv
`default_nettype none
// ============================================================================
// Module      : key_event_filter
// Description : Raw push-button levels to clean per-key events (debounced
//               level, press, release, optional auto-repeat). One shared tick
//               prescaler drives W_KEY independent debounce channels.
//               Auto-repeat is enabled by defining KEY_EVENT_REPEAT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module key_event_filter
    import key_event_pkg::*;
#(
    parameter int CLK_MHZ            = 50,
    parameter int W_KEY              = 4,
    parameter int TICK_CYCLES        = CLK_MHZ * 1000 * C_TICK_MS,
    parameter int DEBOUNCE_TICKS     = C_DEBOUNCE_TICKS,
    parameter int REPEAT_DELAY_TICKS = C_REPEAT_DELAY_TICKS,
    parameter int REPEAT_RATE_TICKS  = C_REPEAT_RATE_TICKS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [W_KEY-1:0] i_key,
    output logic [W_KEY-1:0] o_pressed,
    output logic [W_KEY-1:0] o_press,
    output logic [W_KEY-1:0] o_release,
    output logic [W_KEY-1:0] o_repeat
);

    localparam int                 C_TICK_W    = clog2_min1(TICK_CYCLES);
    localparam logic [C_TICK_W-1:0] C_TICK_LAST = C_TICK_W'(TICK_CYCLES - 1);

    logic [C_TICK_W-1:0] r_tick_cnt;
    logic                w_tick;

    // With TICK_CYCLES = 1 the count sits at 0 and every cycle is a tick
    assign w_tick = (r_tick_cnt == C_TICK_LAST);

    // Shared tick prescaler counting 0 .. TICK_CYCLES-1
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tick_cnt <= '0;
        end else if (w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
        end
    end

    generate
        for (genvar gi = 0; gi < W_KEY; gi++) begin : g_key
            key_debounce_channel #(
                .DEBOUNCE_TICKS     (DEBOUNCE_TICKS),
                .REPEAT_DELAY_TICKS (REPEAT_DELAY_TICKS),
                .REPEAT_RATE_TICKS  (REPEAT_RATE_TICKS)
            ) u_channel (
                .clk       (clk),
                .rst       (rst),
                .i_tick    (w_tick),
                .i_key     (i_key[gi]),
                .o_pressed (o_pressed[gi]),
                .o_press   (o_press[gi]),
                .o_release (o_release[gi]),
                .o_repeat  (o_repeat[gi])
            );
        end
    endgenerate

endmodule : key_event_filter
`default_nettype wire

// File: tb/tb_key_event_filter.sv
`default_nettype none
// ============================================================================
// Module      : tb_key_event_filter
// Description : Scoreboard bench for key_event_filter. Two instances share
//               the key inputs: one ticking every cycle, one every 4 cycles.
//               A behavioural model pushes the expected outputs each edge;
//               a monitor pops and compares on the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_key_event_filter;

    localparam int DEB   = 3;
    localparam int DELAY = 8;
    localparam int RATE  = 4;

    typedef struct packed {
        logic [3:0] pressed;
        logic [3:0] press;
        logic [3:0] rel;
        logic [3:0] rep;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] key = 4'b0001;

    logic [3:0] pressed0, press0, release0, repeat0;
    logic [3:0] pressed1, press1, release1, repeat1;

    int n_checks = 0;
    int n_errors = 0;

    exp_t q0[$];
    exp_t q1[$];

    always #5 clk = ~clk;

    key_event_filter #(
        .CLK_MHZ(50), .W_KEY(4), .TICK_CYCLES(1), .DEBOUNCE_TICKS(DEB),
        .REPEAT_DELAY_TICKS(DELAY), .REPEAT_RATE_TICKS(RATE)
    ) dut (
        .clk(clk), .rst(rst), .i_key(key),
        .o_pressed(pressed0), .o_press(press0),
        .o_release(release0), .o_repeat(repeat0)
    );

    key_event_filter #(
        .CLK_MHZ(50), .W_KEY(4), .TICK_CYCLES(4), .DEBOUNCE_TICKS(DEB),
        .REPEAT_DELAY_TICKS(DELAY), .REPEAT_RATE_TICKS(RATE)
    ) dut4 (
        .clk(clk), .rst(rst), .i_key(key),
        .o_pressed(pressed1), .o_press(press1),
        .o_release(release1), .o_repeat(repeat1)
    );

    // ---------------- reference model ----------------
    // Per instance: cycles since reset, the key as seen two cycles late,
    // the debounced level, the mismatch run in ticks, ticks since press.
    int   m_cyc   [2];
    bit   m_h1    [2][4];
    bit   m_h2    [2][4];
    bit   m_lvl   [2][4];
    int   m_run   [2][4];
    int   m_since [2][4];
    exp_t m_e;
    int   m_T;
    bit   m_tk;
    bit   m_s;

    always @(posedge clk) begin
        for (int inst = 0; inst < 2; inst++) begin
            m_e = '0;
            m_T = (inst == 0) ? 1 : 4;
            if (rst) begin
                m_cyc[inst] = 0;
                for (int k = 0; k < 4; k++) begin
                    m_h1[inst][k]    = 1'b0;
                    m_h2[inst][k]    = 1'b0;
                    m_lvl[inst][k]   = 1'b0;
                    m_run[inst][k]   = 0;
                    m_since[inst][k] = 0;
                end
            end else begin
                m_tk = ((m_cyc[inst] % m_T) == (m_T - 1));
                for (int k = 0; k < 4; k++) begin
                    m_s = m_h2[inst][k];
                    if (m_s == m_lvl[inst][k]) begin
                        m_run[inst][k] = 0;
                    end else if (m_tk) begin
                        m_run[inst][k] = m_run[inst][k] + 1;
                        if (m_run[inst][k] == DEB) begin
                            m_run[inst][k] = 0;
                            m_lvl[inst][k] = m_s;
                            if (m_s) m_e.press[k] = 1'b1;
                            else     m_e.rel[k]   = 1'b1;
                        end
                    end
`ifdef KEY_EVENT_REPEAT_EN
                    if (m_e.press[k]) begin
                        m_since[inst][k] = 0;
                    end else if (m_lvl[inst][k] && m_tk) begin
                        m_since[inst][k] = m_since[inst][k] + 1;
                        if (m_since[inst][k] >= DELAY &&
                            ((m_since[inst][k] - DELAY) % RATE) == 0)
                            m_e.rep[k] = 1'b1;
                    end
`endif
                    m_e.pressed[k] = m_lvl[inst][k];
                    m_h2[inst][k]  = m_h1[inst][k];
                    m_h1[inst][k]  = key[k];
                end
                m_cyc[inst] = m_cyc[inst] + 1;
            end
            if (inst == 0) q0.push_back(m_e);
            else           q1.push_back(m_e);
        end
    end

    // ---------------- monitor ----------------
    task automatic cmp(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s t=%0t actual=%b expected=%b", name, $time, act, exp);
        end
    endtask

    exp_t mon_e;

    always @(negedge clk) begin
        if (q0.size() == 0) begin
            n_checks++; n_errors++;
            $display("FAIL q0_empty t=%0t actual=0 entries expected=1", $time);
        end else begin
            mon_e = q0.pop_front();
            cmp("t1_pressed", pressed0, mon_e.pressed);
            cmp("t1_press",   press0,   mon_e.press);
            cmp("t1_release", release0, mon_e.rel);
            cmp("t1_repeat",  repeat0,  mon_e.rep);
        end
        if (q1.size() == 0) begin
            n_checks++; n_errors++;
            $display("FAIL q1_empty t=%0t actual=0 entries expected=1", $time);
        end else begin
            mon_e = q1.pop_front();
            cmp("t4_pressed", pressed1, mon_e.pressed);
            cmp("t4_press",   press1,   mon_e.press);
            cmp("t4_release", release1, mon_e.rel);
            cmp("t4_repeat",  repeat1,  mon_e.rep);
        end
    end

    // ---------------- stimulus ----------------
    // Inputs change 1 time unit after the falling edge, clear of both edges
    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    // Asserting reset must clear every output at once
    task automatic reset_pulse(input int n);
        rst = 1'b1;
        #1;
        cmp("rst_now_pressed", pressed0 | pressed1, 4'b0000);
        cmp("rst_now_events",  press0 | release0 | repeat0 | press1 | release1 | repeat1, 4'b0000);
        wait_cyc(n);
        rst = 1'b0;
    endtask

    initial begin
        // reset with key[0] held
        wait_cyc(4);
        rst = 1'b0;
        wait_cyc(14);
        // bouncing press on key[1]
        key[1] = 1'b1; wait_cyc(2);
        key[1] = 1'b0; wait_cyc(2);
        key[1] = 1'b1; wait_cyc(2);
        key[1] = 1'b0; wait_cyc(2);
        key[1] = 1'b1; wait_cyc(16);
        // glitch during hold, then steady release
        key[1] = 1'b0; wait_cyc(2);
        key[1] = 1'b1; wait_cyc(16);
        key[1] = 1'b0; wait_cyc(16);
        // auto-repeat, then a release landing on a repeat edge
        key[2] = 1'b1; wait_cyc(40);
        key[2] = 1'b0; wait_cyc(16);
        key[2] = 1'b1; wait_cyc(20);
        key[2] = 1'b0; wait_cyc(16);
        // simultaneous keys 0 and 3
        key[0] = 1'b0; wait_cyc(20);
        key[0] = 1'b1; key[3] = 1'b1; wait_cyc(24);
        key[0] = 1'b0; key[3] = 1'b0; wait_cyc(24);
        // reset while key[2] is held and repeating
        key[2] = 1'b1; wait_cyc(22);
        reset_pulse(3);
        wait_cyc(30);
        key[2] = 1'b0; wait_cyc(20);
        // randomized toggling with bounce-length and long holds
        for (int it = 0; it < 120; it++) begin
            key[$urandom_range(0, 3)] ^= 1'b1;
            if ($urandom_range(0, 3) == 0) wait_cyc($urandom_range(20, 45));
            else                           wait_cyc($urandom_range(1, 8));
            if ($urandom_range(0, 39) == 0) reset_pulse($urandom_range(1, 3));
        end
        key = 4'b0000;
        wait_cyc(40);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_key_event_filter
`default_nettype wire

// File: doc/key_event_filter.md
# key_event_filter

Upstream input stage for the lab tops. It turns raw, bouncing push-button levels into clean per-key events: a debounced level, a one-cycle press pulse, a one-cycle release pulse and, optionally, an auto-repeat pulse. The period/frequency controls and counters downstream consume these pulses directly, so they carry no edge-detect logic of their own.

## Interface
- `clk_mhz`, default 50: system clock in MHz; sets the default tick period.
- `w_key`, default 4: number of keys.
- `tick_cycles`, default `clk_mhz*1000`: clk cycles per tick (1 ms by default); must be ≥ 1.
- `debounce_ticks`, default 10: consecutive mismatching ticks required to flip a debounced level; must be ≥ 1.
- `repeat_delay_ticks`, default 500: ticks from press to the first repeat pulse; must be ≥ 1.
- `repeat_rate_ticks`, default 100: ticks between later repeat pulses; must be ≥ 1.
- `clk`, in, 1: the single clock. Everything is on `posedge clk`.
- `rst`, in, 1: reset, asynchronous and active-high.
- `key`, in, `w_key`: raw key levels, asynchronous, 1 = pressed.
- `pressed`, out, `w_key`: debounced key level.
- `press`, out, `w_key`: one-cycle pulse on each debounced 0→1 transition.
- `release`, out, `w_key`: one-cycle pulse on each debounced 1→0 transition.
- `repeat`, out, `w_key`: one-cycle auto-repeat pulse.

## Operation
- **Reset.** All outputs are registered and reset to 0. Reset also clears every synchronizer flop, every counter and the tick prescaler.
- **Synchronizer.** Each `key` bit passes through a 2-flop synchronizer; call its output `s`.
- **Tick prescaler.** A shared counter runs 0 … `tick_cycles`−1 and wraps. `tick` is high in the cycle the count equals `tick_cycles`−1. With `tick_cycles` = 1, `tick` is high every cycle.
- **Debounce (per key).**
  - In any cycle where `s` equals `pressed`, the counter clears to 0.
  - On a tick cycle where `s` differs from `pressed`:
    - if the counter equals `debounce_ticks`−1, `pressed` flips at that edge and the counter clears;
    - otherwise the counter increments.
  - Counter width is `$clog2(debounce_ticks)`, with a minimum of 1.
- **Events.** `press` and `release` are registered on the same edge that flips `pressed`, so each is high for exactly the first cycle of the new level.
- **Independence.** Keys are fully independent; any number of keys may change in the same cycle.
- **Repeat (per key).**
  - On the press edge, the counter loads `repeat_delay_ticks`−1.
  - On each tick while `pressed` = 1 and not falling at that edge:
    - if the counter is 0, `repeat` pulses and the counter loads `repeat_rate_ticks`−1;
    - otherwise the counter decrements.
  - While `pressed` = 0 the counter is held at 0.
  - If a release and a would-be repeat coincide, release wins and no repeat pulse is produced.
- **Reset mid-hold.** A key held through reset deassertion is seen as a new press after debounce.

## Timing
- With `tick_cycles` = 1, `pressed` changes exactly 2 + `debounce_ticks` cycles after a steady `key` change. The 2 cycles are the synchronizer.
- With `tick_cycles` > 1, the debounce latency is quantized to tick edges, with up to 1 tick of jitter. Flips happen only at tick edges.
- With `tick_cycles` = 1, the first `repeat` comes `repeat_delay_ticks` cycles after the `press` pulse. Later repeats come every `repeat_rate_ticks` cycles.
- There is no combinational path from `key` to any output.

## Configuration
- Macro: `KEY_EVENT_REPEAT_EN`.
- **Defined:** the per-key repeat counters and the `repeat` output operate as described above.
- **Undefined:** no repeat counters are synthesized and `repeat` is tied to 0. The `repeat_*` parameters are accepted but ignored.

## Structure
- **Package `key_event_pkg`:**
  - default-constant localparams (tick_ms = 1, default debounce/delay/rate);
  - a `clog2_min1` width function used for the counter widths.
- **Sub-module `key_debounce_channel`:** one key's synchronizer, debounce counter, edge flops and repeat counter.
  - Instantiated `w_key` times in a generate loop.
  - All channels share the single tick prescaler, which lives in the top module.

## Test plan
Unless noted, the bench uses `tick_cycles`=1, `debounce_ticks`=3, `repeat_delay_ticks`=8, `repeat_rate_ticks`=4, with `KEY_EVENT_REPEAT_EN` defined.

1. **Reset with key held.** `rst` high with `key[0]`=1, then `rst` dropped → all outputs 0 during reset. `pressed[0]` rises 5 cycles after `rst` falls. `press[0]` is high for exactly that one cycle.
2. **Bouncing press.** `key[1]` toggles 1,0,1,0 with 2-cycle phases, then holds 1 → no event during the bounce. Exactly one `press[1]`, 5 cycles after the final rise.
3. **Glitch during hold, then release.** While `key[1]` is held, a 2-cycle 0 glitch → no `release`. A steady 0 → `release[1]` 5 cycles later, and `pressed[1]` = 0.
4. **Auto-repeat.** `key[2]` held 30 cycles past `press` → `repeat[2]` at press+8, +12, +16, +20, +24, +28. Releasing so that the fall lands on a repeat cycle → `release` only, no repeat. With the macro undefined, `repeat` stays 0.
5. **Simultaneous keys and tick quantization.** `key[0]` and `key[3]` rise in the same cycle → both `press` pulses in the same cycle. Rerun with `tick_cycles`=4 → flips occur only on tick cycles, within 2 + 3·4 + 4 cycles.
6. **Reset mid-repeat.** `rst` pulsed while `key[2]` is held and repeating → all outputs 0 immediately. After `rst` falls, a fresh `press[2]` comes 5 cycles later, then the first `repeat` at press+8.
